multicycle_control_unit: RTL and testbench

- Control unit for the multicycle ARM datapath; successor to the single-cycle control unit.
- Replaces pure decode with a main FSM, a registered condition/flags unit, and parameterised ALU-control width.
- Adds programmable memory wait states for FETCH and MEMREAD.
- Sits between the instruction register and the shared-memory multicycle datapath.

---
 rtl/cu_pkg.sv | 64 ++++++
 rtl/cond_logic.sv | 35 +++
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Purpose: shared types and constants for the multicycle ARM control unit.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: FSM state enum, Op codes, condition codes, DP cmd codes, ALU opcodes, cond_eval().
package cu_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB,
    MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  // Instruction classes (Instr[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // Condition codes (Instr[31:28])
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  // Data-processing cmd field (Funct[4:1])
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALU opcodes, sized to the widest supported ALUControl
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

  // flags = {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// Purpose: holds the NZCV flags register and the registered condition result CondExReg.
// Latency: CondExReg loads at the end of DECODE; flags load at the end of EXECUTE*.
// Backpressure: none; loads happen only when the strobes are asserted.
// Ports: CLK, reset (async active-low), cond, aluflags, flagw, ld_condex, upd_flags -> condexreg, flags.
module cond_logic
  import cu_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  input  logic       ld_condex,
  input  logic       upd_flags,
  output logic       condexreg,
  output logic [3:0] flags
);

  // Flag writes depend on the condition registered in DECODE, never on this
  // cycle's evaluation, so an instruction sees only the flags from earlier ones.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      flags     <= 4'b0000;
      condexreg <= 1'b0;
    end else begin
      if (ld_condex)
        condexreg <= cond_eval(cond, flags);
      if (upd_flags && flagw[1] && condexreg)
        flags[3:2] <= aluflags[3:2];
      if (upd_flags && flagw[0] && condexreg)
        flags[1:0] <= aluflags[1:0];
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: main FSM and ALU decoder for the multicycle ARM datapath.
// Latency: FETCH and MEMREAD each take 1+MEM_LAT cycles; other states take one cycle.
// Backpressure: none; memory wait states come from the fixed MEM_LAT count.
// Ports: CLK, reset (async active-low), Instr[31:12], ALUFlags -> write enables, mux selects, ALUControl.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int ALUCTRL_W = 2,
  parameter int MEM_LAT   = 0
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           RegSrc,
  output logic [1:0]           ImmSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  // Instr is bits 31:12, so Instr[i] is architectural bit i+12
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;
  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  assign RegSrc = {op == OP_MEM, op == OP_BR};
  assign ImmSrc = op;

  state_t     state, next;
  logic [3:0] wcnt;
  logic       wait_done;
  logic       condexreg;
  logic [3:0] flags;

  // ALU decode
  logic [2:0] alu_op;
  logic       nowrite;
  logic [1:0] flagw;

  always_comb begin
    alu_op  = ALU_ADD;
    nowrite = 1'b0;
    case (funct[4:1])
      CMD_SUB: alu_op = ALU_SUB;
      CMD_AND: alu_op = ALU_AND;
      CMD_ORR: alu_op = ALU_ORR;
      CMD_CMP: begin
        alu_op  = ALU_SUB;
        nowrite = 1'b1;
      end
      CMD_EOR: if (ALUCTRL_W >= 3) alu_op = ALU_EOR;
      default: alu_op = ALU_ADD;
    endcase
  end

  // CMP always sets all flags; other ops only with S, logical ops leave C/V alone
  always_comb begin
    flagw = 2'b00;
    if (funct[4:1] == CMD_CMP)
      flagw = 2'b11;
    else if (funct[0])
      flagw = (alu_op == ALU_AND || alu_op == ALU_ORR || alu_op == ALU_EOR) ? 2'b10 : 2'b11;
  end

  cond_logic u_cond (
    .CLK       (CLK),
    .reset     (reset),
    .cond      (cond),
    .aluflags  (ALUFlags),
    .flagw     (flagw),
    .ld_condex (state == DECODE),
    .upd_flags (state == EXECUTER || state == EXECUTEI),
    .condexreg (condexreg),
    .flags     (flags)
  );

  // Wait counter counts up in the memory states and is zero everywhere else,
  // so each FETCH/MEMREAD visit starts from zero.
  assign wait_done = (wcnt == LAT);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      wcnt <= 4'd0;
    else if ((state == FETCH || state == MEMREAD) && !wait_done)
      wcnt <= wcnt + 4'd1;
    else
      wcnt <= 4'd0;
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next;
  end

  logic pcw, irw, rgw, mmw;

  // Defaults are the FETCH mux settings so reset shows FETCH selects.
  always_comb begin
    next       = state;
    pcw        = 1'b0;
    irw        = 1'b0;
    rgw        = 1'b0;
    mmw        = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b1;
    ALUSrcB    = 2'b10;
    ResultSrc  = 2'b10;
    ALUControl = ALUCTRL_W'(ALU_ADD);
    case (state)
      FETCH: begin
        if (wait_done) begin
          irw  = 1'b1;
          pcw  = 1'b1;
          next = DECODE;
        end
      end
      DECODE: begin
        case (op)
          OP_MEM:  next = MEMADR;
          OP_DP:   next = funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b0;
        ALUSrcB = 2'b01;
        next    = funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
        if (wait_done) next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        rgw       = condexreg;
        next      = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mmw    = condexreg;
        next   = FETCH;
      end
      EXECUTER, EXECUTEI: begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = (state == EXECUTEI) ? 2'b01 : 2'b00;
        ALUControl = ALUCTRL_W'(alu_op);
        next       = ALUWB;
      end
      ALUWB: begin
        ResultSrc = 2'b00;
        rgw       = condexreg & ~nowrite;
        pcw       = condexreg & ~nowrite & (rd == 4'hF);
        next      = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = condexreg;
        next      = FETCH;
      end
      default: next = FETCH;
    endcase
  end

  // FETCH with no wait states would otherwise assert IRWrite/PCWrite during reset
  assign PCWrite  = reset & pcw;
  assign IRWrite  = reset & irw;
  assign RegWrite = reset & rgw;
  assign MemWrite = reset & mmw;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;
  import cu_pkg::*;

  localparam logic [19:0] I_ADD    = 20'hE0821;
  localparam logic [19:0] I_CMP    = 20'hE1510;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_LDR    = 20'hE5921;
  localparam logic [19:0] I_STR_EQ = 20'h05821;
  localparam logic [19:0] I_STR_AL = 20'hE5821;
  localparam logic [19:0] I_UNDEF  = 20'hEC000;
  localparam logic [19:0] I_EOR    = 20'hE0221;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // instance a: ALUCTRL_W=2, MEM_LAT=0
  logic        rst_a;
  logic [19:0] instr_a;
  logic [3:0]  flg_a;
  logic        pcw_a, irw_a, rw_a, mw_a, adr_a, asa_a;
  logic [1:0]  regsrc_a, immsrc_a, asb_a, rs_a, aluc_a;

  // instance b: ALUCTRL_W=2, MEM_LAT=2
  logic        rst_b;
  logic [19:0] instr_b;
  logic [3:0]  flg_b;
  logic        pcw_b, irw_b, rw_b, mw_b, adr_b, asa_b;
  logic [1:0]  regsrc_b, immsrc_b, asb_b, rs_b, aluc_b;

  // instance c: ALUCTRL_W=3, MEM_LAT=0
  logic        rst_c;
  logic [19:0] instr_c;
  logic [3:0]  flg_c;
  logic        pcw_c, irw_c, rw_c, mw_c, adr_c, asa_c;
  logic [1:0]  regsrc_c, immsrc_c, asb_c, rs_c;
  logic [2:0]  aluc_c;

  multicycle_control_unit #(.ALUCTRL_W(2), .MEM_LAT(0)) dut_a (
    .CLK(CLK), .reset(rst_a), .Instr(instr_a), .ALUFlags(flg_a),
    .PCWrite(pcw_a), .IRWrite(irw_a), .RegWrite(rw_a), .MemWrite(mw_a),
    .AdrSrc(adr_a), .RegSrc(regsrc_a), .ImmSrc(immsrc_a), .ALUSrcA(asa_a),
    .ALUSrcB(asb_a), .ResultSrc(rs_a), .ALUControl(aluc_a));

  multicycle_control_unit #(.ALUCTRL_W(2), .MEM_LAT(2)) dut_b (
    .CLK(CLK), .reset(rst_b), .Instr(instr_b), .ALUFlags(flg_b),
    .PCWrite(pcw_b), .IRWrite(irw_b), .RegWrite(rw_b), .MemWrite(mw_b),
    .AdrSrc(adr_b), .RegSrc(regsrc_b), .ImmSrc(immsrc_b), .ALUSrcA(asa_b),
    .ALUSrcB(asb_b), .ResultSrc(rs_b), .ALUControl(aluc_b));

  multicycle_control_unit #(.ALUCTRL_W(3), .MEM_LAT(0)) dut_c (
    .CLK(CLK), .reset(rst_c), .Instr(instr_c), .ALUFlags(flg_c),
    .PCWrite(pcw_c), .IRWrite(irw_c), .RegWrite(rw_c), .MemWrite(mw_c),
    .AdrSrc(adr_c), .RegSrc(regsrc_c), .ImmSrc(immsrc_c), .ALUSrcA(asa_c),
    .ALUSrcB(asb_c), .ResultSrc(rs_c), .ALUControl(aluc_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rst_a = 1'b0; instr_a = I_ADD; flg_a = 4'h0;
    rst_b = 1'b0; instr_b = I_LDR; flg_b = 4'h0;
    rst_c = 1'b0; instr_c = I_EOR; flg_c = 4'h0;
    #1;

    // ---- reset state (instance a) ----
    chk("rst_state",   32'(dut_a.state), 32'(FETCH));
    chk("rst_flags",   32'(dut_a.u_cond.flags), 32'h0);
    chk("rst_condex",  32'(dut_a.u_cond.condexreg), 32'h0);
    chk("rst_pcw",     32'(pcw_a), 32'h0);
    chk("rst_irw",     32'(irw_a), 32'h0);
    chk("rst_rw",      32'(rw_a), 32'h0);
    chk("rst_mw",      32'(mw_a), 32'h0);
    chk("rst_asa",     32'(asa_a), 32'h1);
    chk("rst_asb",     32'(asb_a), 32'h2);
    chk("rst_rs",      32'(rs_a), 32'h2);
    chk("rst_adr",     32'(adr_a), 32'h0);
    tick();
    rst_a = 1'b1;
    #1;

    // ---- ADD R1,R2,R3 ----
    chk("add_fetch_irw", 32'(irw_a), 32'h1);
    chk("add_fetch_pcw", 32'(pcw_a), 32'h1);
    tick();
    chk("add_dec_state", 32'(dut_a.state), 32'(DECODE));
    chk("add_dec_irw",   32'(irw_a), 32'h0);
    chk("add_dec_rw",    32'(rw_a), 32'h0);
    tick();
    chk("add_exr_state", 32'(dut_a.state), 32'(EXECUTER));
    chk("add_exr_aluc",  32'(aluc_a), 32'h0);
    chk("add_exr_asb",   32'(asb_a), 32'h0);
    chk("add_exr_asa",   32'(asa_a), 32'h0);
    chk("add_exr_rw",    32'(rw_a), 32'h0);
    tick();
    chk("add_wb_state",  32'(dut_a.state), 32'(ALUWB));
    chk("add_wb_rw",     32'(rw_a), 32'h1);
    chk("add_wb_rs",     32'(rs_a), 32'h0);
    chk("add_wb_pcw",    32'(pcw_a), 32'h0);
    tick();
    chk("add_next_fetch", 32'(dut_a.state), 32'(FETCH));
    chk("add_next_rw",    32'(rw_a), 32'h0);

    // ---- CMP with Z=1, then BEQ taken ----
    instr_a = I_CMP; flg_a = 4'b0100;
    tick();
    chk("cmp_dec_rw", 32'(rw_a), 32'h0);
    tick();
    chk("cmp_exr_rw",   32'(rw_a), 32'h0);
    chk("cmp_exr_aluc", 32'(aluc_a), 32'h1);
    tick();
    chk("cmp_wb_rw",    32'(rw_a), 32'h0);
    chk("cmp_flags_z",  32'(dut_a.u_cond.flags), 32'h4);
    tick();
    instr_a = I_BEQ; flg_a = 4'b0000;
    tick();
    chk("beq_regsrc", 32'(regsrc_a), 32'h1);
    chk("beq_immsrc", 32'(immsrc_a), 32'h2);
    tick();
    chk("beq_state",  32'(dut_a.state), 32'(BRANCH));
    chk("beq_t_pcw",  32'(pcw_a), 32'h1);
    chk("beq_asb",    32'(asb_a), 32'h1);
    tick();

    // ---- CMP with Z=0, then BEQ not taken ----
    instr_a = I_CMP; flg_a = 4'b0000;
    tick(); tick(); tick();
    chk("cmp2_flags", 32'(dut_a.u_cond.flags), 32'h0);
    tick();
    instr_a = I_BEQ;
    tick(); tick();
    chk("beq_nt_state", 32'(dut_a.state), 32'(BRANCH));
    chk("beq_nt_pcw",   32'(pcw_a), 32'h0);
    tick();

    // ---- STREQ with Z=0: no memory write ----
    instr_a = I_STR_EQ;
    tick(); tick();
    chk("streq_madr_state", 32'(dut_a.state), 32'(MEMADR));
    chk("streq_madr_asb",   32'(asb_a), 32'h1);
    chk("streq_madr_mw",    32'(mw_a), 32'h0);
    tick();
    chk("streq_mw_state", 32'(dut_a.state), 32'(MEMWRITE));
    chk("streq_mw",       32'(mw_a), 32'h0);
    chk("streq_adr",      32'(adr_a), 32'h1);
    tick();

    // ---- STR always: memory write happens ----
    instr_a = I_STR_AL;
    tick(); tick(); tick();
    chk("stral_mw", 32'(mw_a), 32'h1);
    tick();

    // ---- undefined Op=11 returns to FETCH with no writes ----
    instr_a = I_UNDEF;
    tick();
    chk("undef_dec_rw", 32'(rw_a), 32'h0);
    tick();
    chk("undef_state", 32'(dut_a.state), 32'(FETCH));

    // ---- set all flags, then reset during EXECUTER ----
    instr_a = I_CMP; flg_a = 4'hF;
    tick(); tick(); tick();
    chk("cmp3_flags", 32'(dut_a.u_cond.flags), 32'hF);
    tick();
    instr_a = I_ADD; flg_a = 4'h0;
    tick(); tick();
    chk("abort_pre_state", 32'(dut_a.state), 32'(EXECUTER));
    rst_a = 1'b0;
    #1;
    chk("abort_state", 32'(dut_a.state), 32'(FETCH));
    chk("abort_flags", 32'(dut_a.u_cond.flags), 32'h0);
    chk("abort_we",    32'({pcw_a, irw_a, rw_a, mw_a}), 32'h0);
    tick();
    chk("abort_hold_we", 32'({pcw_a, irw_a, rw_a, mw_a}), 32'h0);
    rst_a = 1'b1;
    #1;
    chk("abort_release_irw", 32'(irw_a), 32'h1);

    // ---- EOR with 2-bit ALUControl decodes as ADD ----
    instr_a = I_EOR;
    tick(); tick();
    chk("eor_w2_aluc", 32'(aluc_a), 32'h0);

    // ---- LDR with MEM_LAT=2 (instance b) ----
    tick();
    rst_b = 1'b1;
    #1;
    chk("ldr_f1_irw", 32'(irw_b), 32'h0);
    tick();
    chk("ldr_f2_irw", 32'(irw_b), 32'h0);
    chk("ldr_f2_state", 32'(dut_b.state), 32'(FETCH));
    tick();
    chk("ldr_f3_irw", 32'(irw_b), 32'h1);
    chk("ldr_f3_pcw", 32'(pcw_b), 32'h1);
    tick();
    chk("ldr_dec_state",  32'(dut_b.state), 32'(DECODE));
    chk("ldr_dec_regsrc", 32'(regsrc_b), 32'h2);
    chk("ldr_dec_immsrc", 32'(immsrc_b), 32'h1);
    tick();
    chk("ldr_madr_state", 32'(dut_b.state), 32'(MEMADR));
    tick();
    chk("ldr_mr1_adr", 32'(adr_b), 32'h1);
    chk("ldr_mr1_rs",  32'(rs_b), 32'h0);
    chk("ldr_mr1_rw",  32'(rw_b), 32'h0);
    tick();
    chk("ldr_mr2_state", 32'(dut_b.state), 32'(MEMREAD));
    tick();
    chk("ldr_mr3_state", 32'(dut_b.state), 32'(MEMREAD));
    chk("ldr_mr3_rw",    32'(rw_b), 32'h0);
    tick();
    chk("ldr_wb_state", 32'(dut_b.state), 32'(MEMWB));
    chk("ldr_wb_rw",    32'(rw_b), 32'h1);
    chk("ldr_wb_rs",    32'(rs_b), 32'h1);
    tick();
    chk("ldr_next_state", 32'(dut_b.state), 32'(FETCH));
    chk("ldr_next_irw",   32'(irw_b), 32'h0);

    // ---- EOR with 3-bit ALUControl (instance c) ----
    rst_c = 1'b1;
    #1;
    tick(); tick();
    chk("eor_w3_state", 32'(dut_c.state), 32'(EXECUTER));
    chk("eor_w3_aluc",  32'(aluc_c), 32'h4);
    tick();
    chk("eor_w3_wb_rw", 32'(rw_c), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
